// File: rtl/usb_task_scheduler.sv
// Round-robin scheduler sharing one read/write task FSM between two requesters,
// with bounded retry after failed attempts and a registered response path.
module usb_task_scheduler #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_write,
    input  logic [31:0]  req_mempage,
    input  logic [127:0] req_wdata,
    output logic [1:0]   req_ack,
    output logic [1:0]   resp_valid,
    output logic         resp_ok,
    output logic [63:0]  resp_rdata,
    output logic         task_avail,
    output logic [1:0]   id,
    output logic [15:0]  mempage,
    output logic [63:0]  data_in,
    input  logic         task_taken,
    input  logic         success_out,
    input  logic [63:0]  data_out,
    output logic [7:0]   fail_count,
    output logic         busy
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GapW   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
    // Gap counter runs RETRY_GAP-1 down to 0, giving RETRY_GAP idle cycles
    localparam logic [GapW-1:0]   GapLoad  = GapW'(RETRY_GAP - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StResp} state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              owner_q, owner_d;
    logic              write_q, write_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [1:0]        req_ack_q, req_ack_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic              resp_ok_q, resp_ok_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic              task_avail_q, task_avail_d;
    logic [1:0]        id_q, id_d;
    logic [15:0]       mempage_q, mempage_d;
    logic [63:0]       data_in_q, data_in_d;
    logic [7:0]        fail_count_q, fail_count_d;
    logic              busy_q, busy_d;
    logic              gnt;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        write_d      = write_q;
        retry_d      = retry_q;
        gap_d        = gap_q;
        req_ack_d    = 2'b00;
        resp_valid_d = 2'b00;
        resp_ok_d    = 1'b0;
        resp_rdata_d = 64'd0;
        task_avail_d = task_avail_q;
        id_d         = id_q;
        mempage_d    = mempage_q;
        data_in_d    = data_in_q;
        fail_count_d = fail_count_q;
        gnt          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    // req1 wins when alone, or when both request and it holds the pointer
                    gnt            = req_valid[1] & (~req_valid[0] | rr_ptr_q);
                    rr_ptr_d       = ~gnt;
                    owner_d        = gnt;
                    write_d        = req_write[gnt];
                    retry_d        = '0;
                    req_ack_d[gnt] = 1'b1;
                    mempage_d      = gnt ? req_mempage[31:16] : req_mempage[15:0];
                    data_in_d      = gnt ? req_wdata[127:64] : req_wdata[63:0];
                    task_avail_d   = 1'b1;
                    id_d           = req_write[gnt] ? 2'b10 : 2'b01;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                if (task_taken) begin
                    task_avail_d = 1'b0;
                    id_d         = 2'b00;
                    if (success_out) begin
                        resp_valid_d[owner_q] = 1'b1;
                        resp_ok_d             = 1'b1;
                        resp_rdata_d          = write_q ? 64'd0 : data_out;
                        state_d               = StResp;
                    end else begin
                        if (fail_count_q != 8'hFF) begin
                            fail_count_d = fail_count_q + 8'd1;
                        end
                        if (retry_q < MaxRetry) begin
                            retry_d = retry_q + 1'b1;
                            gap_d   = GapLoad;
                            state_d = StGap;
                        end else begin
                            resp_valid_d[owner_q] = 1'b1;
                            state_d               = StResp;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    task_avail_d = 1'b1;
                    id_d         = write_q ? 2'b10 : 2'b01;
                    state_d      = StIssue;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            retry_q      <= '0;
            gap_q        <= '0;
            req_ack_q    <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_ok_q    <= 1'b0;
            resp_rdata_q <= 64'd0;
            task_avail_q <= 1'b0;
            id_q         <= 2'b00;
            mempage_q    <= 16'd0;
            data_in_q    <= 64'd0;
            fail_count_q <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            req_ack_q    <= req_ack_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_rdata_q <= resp_rdata_d;
            task_avail_q <= task_avail_d;
            id_q         <= id_d;
            mempage_q    <= mempage_d;
            data_in_q    <= data_in_d;
            fail_count_q <= fail_count_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_rdata = resp_rdata_q;
    assign task_avail = task_avail_q;
    assign id         = id_q;
    assign mempage    = mempage_q;
    assign data_in    = data_in_q;
    assign fail_count = fail_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_usb_task_scheduler.sv
// Directed bench for usb_task_scheduler: reads, writes, contention, retries, reset.
module tb_usb_task_scheduler;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_write;
    logic [31:0]  req_mempage;
    logic [127:0] req_wdata;
    logic [1:0]   req_ack;
    logic [1:0]   resp_valid;
    logic         resp_ok;
    logic [63:0]  resp_rdata;
    logic         task_avail;
    logic [1:0]   id;
    logic [15:0]  mempage;
    logic [63:0]  data_in;
    logic         task_taken;
    logic         success_out;
    logic [63:0]  data_out;
    logic [7:0]   fail_count;
    logic         busy;

    int total = 0;
    int bad   = 0;

    usb_task_scheduler #(.MAX_RETRY(3), .RETRY_GAP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_mempage (req_mempage),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .resp_valid  (resp_valid),
        .resp_ok     (resp_ok),
        .resp_rdata  (resp_rdata),
        .task_avail  (task_avail),
        .id          (id),
        .mempage     (mempage),
        .data_in     (data_in),
        .task_taken  (task_taken),
        .success_out (success_out),
        .data_out    (data_out),
        .fail_count  (fail_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (req_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", req_ack); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", resp_valid); end
        total++; if (task_avail !== 1'b0 || id !== 2'b00) begin bad++; $display("FAIL reset_task avail=%b id=%b exp=0/00", task_avail, id); end
        total++; if (fail_count !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_cnt fail_count=%0d busy=%b exp=0/0", fail_count, busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req_valid = 2'b01; req_write = 2'b00; req_mempage = 32'h0000_0050;
        tick();
        total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL read_ack got=%b exp=01", req_ack); end
        total++; if (task_avail !== 1'b1 || id !== 2'b01) begin bad++; $display("FAIL read_issue avail=%b id=%b exp=1/01", task_avail, id); end
        total++; if (mempage !== 16'h0050) begin bad++; $display("FAIL read_page got=%h exp=0050", mempage); end
        req_valid = 2'b00;
        tick();
        total++; if (req_ack !== 2'b00 || task_avail !== 1'b1) begin bad++; $display("FAIL read_hold ack=%b avail=%b exp=00/1", req_ack, task_avail); end
        task_taken = 1'b1; success_out = 1'b1; data_out = 64'd90;
        tick();
        task_taken = 1'b0;
        total++; if (task_avail !== 1'b0) begin bad++; $display("FAIL read_drop avail=%b exp=0", task_avail); end
        total++; if (resp_valid !== 2'b01 || resp_ok !== 1'b1) begin bad++; $display("FAIL read_resp valid=%b ok=%b exp=01/1", resp_valid, resp_ok); end
        total++; if (resp_rdata !== 64'd90) begin bad++; $display("FAIL read_rdata got=%0d exp=90", resp_rdata); end
        tick();
        total++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL read_idle valid=%b busy=%b exp=00/0", resp_valid, busy); end
    endtask

    task automatic test_stray_taken();
        task_taken = 1'b1; success_out = 1'b0;
        tick();
        task_taken = 1'b0;
        tick();
        total++; if (fail_count !== 8'd0 || busy !== 1'b0 || resp_valid !== 2'b00) begin
            bad++; $display("FAIL stray_taken fail_count=%0d busy=%b resp=%b exp=0/0/00", fail_count, busy, resp_valid);
        end
    endtask

    task automatic test_single_write();
        req_valid = 2'b10; req_write = 2'b10; req_mempage = 32'h1234_0000;
        req_wdata = {64'd400, 64'd7};
        tick();
        total++; if (req_ack !== 2'b10 || id !== 2'b10) begin bad++; $display("FAIL write_issue ack=%b id=%b exp=10/10", req_ack, id); end
        total++; if (mempage !== 16'h1234) begin bad++; $display("FAIL write_page got=%h exp=1234", mempage); end
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            total++; if (data_in !== 64'd400 || task_avail !== 1'b1) begin
                bad++; $display("FAIL write_hold data_in=%0d avail=%b exp=400/1", data_in, task_avail);
            end
            tick();
        end
        task_taken = 1'b1; success_out = 1'b1; data_out = 64'hDEAD;
        tick();
        task_taken = 1'b0;
        total++; if (resp_valid !== 2'b10 || resp_ok !== 1'b1 || resp_rdata !== 64'd0) begin
            bad++; $display("FAIL write_resp valid=%b ok=%b rdata=%0h exp=10/1/0", resp_valid, resp_ok, resp_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        int pend0, pend1, n;
        logic [1:0] exp_ack;
        logic double_ack;
        apply_reset();
        pend0 = 2; pend1 = 2; double_ack = 1'b0;
        req_valid = 2'b11; req_write = 2'b00; req_mempage = 32'h0002_0001;
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ack === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            if (req_ack === 2'b11) double_ack = 1'b1;
            total++; if (req_ack !== exp_ack) begin
                bad++; $display("FAIL contention_grant%0d got=%b exp=%b", k, req_ack, exp_ack);
                break;
            end
            if (req_ack[0]) pend0--; else pend1--;
            req_valid = {pend1 > 0, pend0 > 0};
            tick();
            task_taken = 1'b1; success_out = 1'b1; data_out = 64'd1;
            tick();
            task_taken = 1'b0;
            total++; if (resp_valid !== exp_ack) begin
                bad++; $display("FAIL contention_resp%0d got=%b exp=%b", k, resp_valid, exp_ack);
            end
            tick();
            if (req_ack !== 2'b00) double_ack = 1'b1;
        end
        req_valid = 2'b00;
        total++; if (double_ack !== 1'b0) begin bad++; $display("FAIL contention_onehot got=%b exp=0", double_ack); end
        tick();
    endtask

    task automatic test_retry_pass();
        int low;
        apply_reset();
        req_valid = 2'b01; req_write = 2'b00; req_mempage = 32'h0000_0A0A;
        tick();
        req_valid = 2'b00;
        task_taken = 1'b1; success_out = 1'b0; data_out = 64'd5;
        tick();
        task_taken = 1'b0;
        total++; if (task_avail !== 1'b0 || id !== 2'b00 || mempage !== 16'h0A0A) begin
            bad++; $display("FAIL retry_gap avail=%b id=%b page=%h exp=0/00/0a0a", task_avail, id, mempage);
        end
        total++; if (fail_count !== 8'd1) begin bad++; $display("FAIL retry_fail_count got=%0d exp=1", fail_count); end
        low = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (task_avail === 1'b1) break;
            low++;
        end
        total++; if (low != 4) begin bad++; $display("FAIL retry_gap_len got=%0d exp=4", low); end
        total++; if (id !== 2'b01) begin bad++; $display("FAIL retry_reissue_id got=%b exp=01", id); end
        task_taken = 1'b1; success_out = 1'b1; data_out = 64'd77;
        tick();
        task_taken = 1'b0;
        total++; if (resp_valid !== 2'b01 || resp_ok !== 1'b1 || resp_rdata !== 64'd77) begin
            bad++; $display("FAIL retry_resp valid=%b ok=%b rdata=%0d exp=01/1/77", resp_valid, resp_ok, resp_rdata);
        end
        tick();
        total++; if (resp_valid !== 2'b00 || fail_count !== 8'd1) begin
            bad++; $display("FAIL retry_single_resp valid=%b fail_count=%0d exp=00/1", resp_valid, fail_count);
        end
    endtask

    task automatic test_retry_exhaust();
        int issues, n;
        logic early_resp;
        apply_reset();
        issues = 0; early_resp = 1'b0;
        req_valid = 2'b10; req_write = 2'b10; req_mempage = 32'h00BB_0000;
        req_wdata = {64'd1234, 64'd0};
        tick();
        req_valid = 2'b00;
        for (int a = 0; a < 4; a++) begin
            n = 0;
            while (task_avail !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (task_avail === 1'b1) issues++;
            task_taken = 1'b1; success_out = 1'b0; data_out = 64'd55;
            tick();
            task_taken = 1'b0;
            if (a < 3 && resp_valid !== 2'b00) early_resp = 1'b1;
        end
        total++; if (resp_valid !== 2'b10 || resp_ok !== 1'b0 || resp_rdata !== 64'd0) begin
            bad++; $display("FAIL exhaust_resp valid=%b ok=%b rdata=%0h exp=10/0/0", resp_valid, resp_ok, resp_rdata);
        end
        total++; if (fail_count !== 8'd4) begin bad++; $display("FAIL exhaust_fail_count got=%0d exp=4", fail_count); end
        total++; if (early_resp !== 1'b0) begin bad++; $display("FAIL exhaust_early_resp got=%b exp=0", early_resp); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (task_avail === 1'b1) issues++;
        end
        total++; if (issues != 4) begin bad++; $display("FAIL exhaust_issues got=%0d exp=4", issues); end
    endtask

    task automatic test_reset_mid_issue();
        logic saw_resp;
        saw_resp = 1'b0;
        req_valid = 2'b01; req_write = 2'b01; req_mempage = 32'h0000_0C0C;
        req_wdata = {64'd0, 64'd99};
        tick();
        req_valid = 2'b00;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if (task_avail !== 1'b0 || id !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_task avail=%b id=%b busy=%b exp=0/00/0", task_avail, id, busy);
        end
        total++; if (mempage !== 16'd0 || data_in !== 64'd0) begin
            bad++; $display("FAIL midreset_data page=%h data_in=%0d exp=0/0", mempage, data_in);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid !== 2'b00) saw_resp = 1'b1;
        end
        total++; if (saw_resp !== 1'b0) begin bad++; $display("FAIL midreset_resp got=%b exp=0", saw_resp); end
        req_valid = 2'b11;
        tick();
        total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL midreset_grant got=%b exp=01", req_ack); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_mempage = 32'd0; req_wdata = 128'd0;
        task_taken = 1'b0; success_out = 1'b0; data_out = 64'd0;
        test_reset();
        test_single_read();
        test_stray_taken();
        test_single_write();
        test_contention();
        test_retry_pass();
        test_retry_exhaust();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
